// File: rtl/rah_tx_pkg.sv
// rah_tx_pkg: shared widths, fill word and frame state encoding for the RAH TX packer
package rah_tx_pkg;
  localparam int DATA_WIDTH = 48;
  localparam int MIPI_WIDTH = 64;
  localparam int ACC_WIDTH  = 112;
  localparam logic [MIPI_WIDTH-1:0] FILL_WORD = 64'h0;
  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBLANK_PRE,
    HSYNC,
    HBACK,
    ACTIVE,
    HFRONT,
    VBLANK_POST
  } state_t;
  // upstream may push data only while a frame is running and not in the closing blank
  function automatic logic accepts(input state_t s);
    return s inside {VSYNC, VBLANK_PRE, HSYNC, HBACK, ACTIVE, HFRONT};
  endfunction
endpackage

// File: rtl/rah_gearbox_48to64.sv
// rah_gearbox_48to64: 112-bit accumulator packing 48-bit packets LSB-first into 64-bit words
module rah_gearbox_48to64
  import rah_tx_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  input  logic                  open_i,
  input  logic                  emit_i,
  output logic                  ready_o,
  output logic [MIPI_WIDTH-1:0] word_o,
  output logic                  pad_o
);
  logic [ACC_WIDTH-1:0] acc_q, acc_d, base;
  logic [6:0]           fill_q, fill_d, base_fill;
  logic                 take, pop;
  // emit frees the low word first, so a same-cycle accept lands at the post-shift offset
  always_comb begin
    ready_o   = open_i && fill_q <= 7'd64;
    take      = valid_i && ready_o;
    pop       = emit_i && fill_q >= 7'd64;
    pad_o     = emit_i && !pop;
    base      = pop ? acc_q >> MIPI_WIDTH : acc_q;
    base_fill = pop ? fill_q - 7'd64 : fill_q;
    acc_d     = take ? base | (ACC_WIDTH'(data_i) << base_fill) : base;
    fill_d    = take ? base_fill + 7'd48 : base_fill;
  end
  assign word_o = acc_q[MIPI_WIDTH-1:0];
  // accumulator and bit count; bits at or above fill are always zero
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      acc_q  <= '0;
      fill_q <= '0;
    end else begin
      acc_q  <= acc_d;
      fill_q <= fill_d;
    end
endmodule

// File: rtl/rah_tx_packer.sv
// rah_tx_packer: 48->64 gearbox plus VSYNC/HSYNC/VALID frame generator; stats counters under RAH_TX_STATS_EN
module rah_tx_packer
  import rah_tx_pkg::*;
#(
  parameter int LINE_WORDS = 480,
  parameter int LINES      = 1024,
  parameter int HSYNC_W    = 2,
  parameter int H_BLANK    = 16,
  parameter int V_BLANK    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mipi_valid,
  output logic                  mipi_hsync,
  output logic                  mipi_vsync,
  output logic [MIPI_WIDTH-1:0] mipi_data,
  output logic                  busy,
  output logic [31:0]           pad_count,
  output logic [15:0]           frame_count
);
  localparam int HMAX = H_BLANK > HSYNC_W ? H_BLANK : HSYNC_W;
  localparam int VMAX = V_BLANK > HMAX ? V_BLANK : HMAX;
  localparam int CMAX = LINE_WORDS > VMAX ? LINE_WORDS : VMAX;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int LW   = LINES > 1 ? $clog2(LINES) : 1;
  localparam logic [CW-1:0] C_VB = CW'(V_BLANK - 1);
  localparam logic [CW-1:0] C_HS = CW'(HSYNC_W - 1);
  localparam logic [CW-1:0] C_HB = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] C_LW = CW'(LINE_WORDS - 1);
  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [LW-1:0]           line_q;
  logic                    valid_q, hsync_q, vsync_q, busy_q;
  logic [MIPI_WIDTH-1:0]   data_q, word;
  logic                    active, pad, last_line;
  assign active    = state_q == ACTIVE;
  assign last_line = line_q == LW'(LINES - 1);
  rah_gearbox_48to64 u_gearbox (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .data_i (in_data),
    .valid_i(in_valid),
    .open_i (accepts(state_q)),
    .emit_i (active),
    .ready_o(in_ready),
    .word_o (word),
    .pad_o  (pad)
  );
  // frame sequencer: shared down-counter reloaded on every state entry, outputs registered from current state
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      valid_q <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= active;
      hsync_q <= state_q == HSYNC;
      vsync_q <= state_q == VSYNC;
      busy_q  <= state_q != IDLE;
      data_q  <= active && !pad ? word : FILL_WORD;
      if (state_q == IDLE) begin
        if (in_valid) begin
          state_q <= VSYNC;
          cnt_q   <= '0;
        end
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CW'(1);
      end else begin
        case (state_q)
          VSYNC:       begin state_q <= VBLANK_PRE; cnt_q <= C_VB; end
          VBLANK_PRE:  begin state_q <= HSYNC;      cnt_q <= C_HS; end
          HSYNC:       begin state_q <= HBACK;      cnt_q <= C_HB; end
          HBACK:       begin state_q <= ACTIVE;     cnt_q <= C_LW; end
          ACTIVE:      begin state_q <= HFRONT;     cnt_q <= C_HB; end
          HFRONT: begin
            state_q <= last_line ? VBLANK_POST : HSYNC;
            cnt_q   <= last_line ? C_VB : C_HS;
            line_q  <= last_line ? '0 : line_q + LW'(1);
          end
          default:     state_q <= IDLE;
        endcase
      end
    end
  assign mipi_valid = valid_q;
  assign mipi_hsync = hsync_q;
  assign mipi_vsync = vsync_q;
  assign mipi_data  = data_q;
  assign busy       = busy_q;
`ifdef RAH_TX_STATS_EN
  logic [31:0] pad_q;
  logic [15:0] frame_q;
  // saturating pad counter and wrapping frame counter; a reset-aborted frame is never counted
  always_ff @(posedge clk)
    if (!rst_n) begin
      pad_q   <= '0;
      frame_q <= '0;
    end else begin
      if (pad && pad_q != '1) pad_q <= pad_q + 32'd1;
      if (state_q == VBLANK_POST && cnt_q == '0) frame_q <= frame_q + 16'd1;
    end
  assign pad_count   = pad_q;
  assign frame_count = frame_q;
`else
  assign pad_count   = '0;
  assign frame_count = '0;
`endif
endmodule

// File: tb/tb_rah_tx_packer.sv
// tb_rah_tx_packer: directed frame/packing checks for rah_tx_packer with a bitstream scoreboard
module tb_rah_tx_packer;
`ifdef RAH_TX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mipi_valid, mipi_hsync, mipi_vsync, busy;
  logic [63:0] mipi_data;
  logic [31:0] pad_count;
  logic [15:0] frame_count;
  int          n_tests = 0, n_fail = 0;
  int          c_busy, c_vs, c_hs, c_val, c_fill;
  logic [63:0] dq[$];
  bit          mq[$];

  rah_tx_packer #(.LINE_WORDS(6), .LINES(2), .HSYNC_W(2), .H_BLANK(2), .V_BLANK(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mipi_valid(mipi_valid), .mipi_hsync(mipi_hsync), .mipi_vsync(mipi_vsync), .mipi_data(mipi_data),
    .busy(busy), .pad_count(pad_count), .frame_count(frame_count)
  );

  initial forever #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pk(input int k);
    return {16'hA000 + 16'(k), 16'hB000 + 16'(k), 16'hC000 + 16'(k)};
  endfunction

  // output monitor: counts frame signals and checks every data word against the accepted bitstream
  always @(negedge clk) begin
    logic [63:0] w;
    if (busy) c_busy++;
    if (mipi_vsync) c_vs++;
    if (mipi_hsync) c_hs++;
    if (mipi_valid) begin
      c_val++;
      if (mipi_data == 64'h0) c_fill++;
      else begin
        dq.push_back(mipi_data);
        w = '0;
        if (mq.size() >= 64) for (int i = 0; i < 64; i++) w[i] = mq.pop_front();
        check("sb_word", mipi_data, w);
      end
    end
    if (rst_n && in_valid && in_ready) for (int i = 0; i < 48; i++) mq.push_back(in_data[i]);
    if (!rst_n) mq.delete();
  end

  task automatic clr;
    c_busy = 0; c_vs = 0; c_hs = 0; c_val = 0; c_fill = 0;
    dq.delete();
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_valid"}, mipi_valid, 0);
    check({tag, "_hsync"}, mipi_hsync, 0);
    check({tag, "_vsync"}, mipi_vsync, 0);
    check({tag, "_data"}, mipi_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, in_ready, 0);
    check({tag, "_pad"}, pad_count, 0);
    check({tag, "_frame"}, frame_count, 0);
  endtask

  task automatic send(input logic [47:0] d);
    logic r;
    r = 1'b0;
    in_data = d;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !r; n++) begin
      @(negedge clk);
      r = in_ready;
    end
    check("send_accept", r, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_idle;
    logic seen, done;
    seen = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
      else if (seen) done = 1'b1;
    end
    check("frame_end", done, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_frame(input string tag, input int fills, input int words);
    check({tag, "_busy_cyc"}, c_busy, 31);
    check({tag, "_vsync_cyc"}, c_vs, 1);
    check({tag, "_hsync_cyc"}, c_hs, 4);
    check({tag, "_valid_cyc"}, c_val, 12);
    check({tag, "_fills"}, c_fill, fills);
    check({tag, "_words"}, dq.size(), words);
  endtask

  initial begin
    logic [47:0] q1, q2;
    logic [63:0] e;
    logic        r;
    int          acc, k, nv;
    q1 = 48'hABCD_EF12_3456;
    q2 = 48'h1357_9BDF_2468;
    do_reset;
    @(negedge clk);
    chk_zero("rst");
    @(posedge clk);
    #1;
    // single packet: whole frame of fill words, 48 bits kept over
    clr;
    send(q1);
    wait_idle;
    chk_frame("single", 12, 0);
    // second frame: the retained packet completes the first word
    clr;
    send(q2);
    wait_idle;
    chk_frame("retain", 11, 1);
    e = {q2[15:0], q1};
    check("retain_word0", dq[0], e);
    check("stats_pad", pad_count, STATS ? 64'd23 : 64'd0);
    check("stats_frame", frame_count, STATS ? 64'd2 : 64'd0);
    // four packets p0..p3 pack into three words
    do_reset;
    clr;
    send(48'h1);
    send(48'h2);
    send(48'h3);
    send(48'h4);
    wait_idle;
    chk_frame("pack4", 9, 3);
    check("pack4_w0", dq[0], 64'h0002_0000_0000_0001);
    check("pack4_w1", dq[1], 64'h0000_0003_0000_0000);
    check("pack4_w2", dq[2], 64'h0000_0000_0004_0000);
    // continuous in_valid across one frame
    clr;
    acc = 0;
    k = 1;
    in_data = pk(k);
    in_valid = 1'b1;
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      r = in_ready;
      if (j == 2) check("cont_rdy_vsync", r, 1);
      if (j == 16 || j == 17 || j == 28 || j == 29) check("cont_rdy_full", r, 0);
      if (j >= 30) check("cont_rdy_vbpost", r, 0);
      @(posedge clk);
      #1;
      if (r) begin
        acc++;
        k++;
        in_data = pk(k);
      end
    end
    in_valid = 1'b0;
    wait_idle;
    check("cont_accepts", acc, 10);
    chk_frame("cont", 6, 6);
    // reset on the third active word of line 0
    clr;
    nv = 0;
    in_data = pk(50);
    in_valid = 1'b1;
    for (int n = 0; n < 100 && nv < 3; n++) begin
      @(negedge clk);
      if (mipi_valid) nv++;
      r = in_ready;
      @(posedge clk);
      #1;
      if (r && in_valid) in_valid = 1'b0;
    end
    check("mid_reach", nv, 3);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_zero("midrst");
    @(posedge clk);
    #1;
    clr;
    send(pk(60));
    wait_idle;
    chk_frame("after_rst", 12, 0);
    check("after_rst_pad", pad_count, STATS ? 64'd12 : 64'd0);
    check("after_rst_frame", frame_count, STATS ? 64'd1 : 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
